ml_decision_tracker: RTL and testbench
======================================

ML_DECISION_TRACKER -- requirements
Module: ml_decision_tracker

Interface
REQ-001 SHALL have parameter N, default 32: fixed-point word width of the incoming min-distance values.
REQ-002 SHALL have parameter Q, default 22: fractional bits; it does not affect the arithmetic here and is passed through to sub-modules.
REQ-003 SHALL have parameter NUM_CAND, default 16: candidates per frame, legal range 2..256.
REQ-004 SHALL have parameter CW, default $clog2(NUM_CAND): candidate index width.
REQ-005 Ports SHALL be:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous reset, active-high.
- in_valid, input, 1: a candidate's min-distance set is present.
- in_ready, output, 1: block accepts a candidate this cycle.
- min_dI1, min_dQ1, min_dI2, min_dQ2, input, N each: signed non-negative per-dimension minimum squared distances.
- min_idx_dI1, min_idx_dQ1, min_idx_dI2, min_idx_dQ2, input, 3 each: PAM level indices (0..3) belonging to those distances.
- out_valid, output, 1: frame decision available.
- out_ready, input, 1: consumer takes the decision.
- best_cand, output, CW: index of the winning candidate within the frame.
- best_metric, output, N+2: winning metric.
- best_sym, output, 12: {idx_I1, idx_Q1, idx_I2, idx_Q2} of the winner.

Function
REQ-006 Metric SHALL be min_dI1+min_dQ1+min_dI2+min_dQ2, computed unsigned at N+2 bits; no saturation is needed and no wrap is possible.
REQ-007 A transfer SHALL occur only on cycles where in_valid && in_ready; input values SHALL be ignored on all other cycles.
REQ-008 The FSM SHALL have states ACC, DRAIN and OUT; reset state is ACC.
REQ-009 In ACC, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-010 In ACC, each transfer SHALL increment the candidate counter cnt, which wraps to 0 after NUM_CAND-1.
REQ-011 The first candidate of a frame (cnt==0) SHALL load the best registers unconditionally.
REQ-012 Each later candidate SHALL replace the best registers only if its metric is strictly less than best_metric; on a tie the lower index wins.
REQ-013 On the transfer with cnt==NUM_CAND-1, the FSM SHALL go to OUT, or to DRAIN when ML_DEC_PIPE_EN is defined.
REQ-014 DRAIN SHALL last exactly one cycle: in_ready=0, the final comparison completes, then the FSM goes to OUT.
REQ-015 In OUT, out_valid SHALL be 1, in_ready SHALL be 0, and best_* SHALL be held stable.
REQ-016 In OUT, out_ready=1 SHALL return the FSM to ACC with cnt=0 on the next cycle; back-pressure is unbounded.
REQ-017 Latency from the last transfer to out_valid SHALL be 1 cycle without ML_DEC_PIPE_EN and 2 cycles with it.
REQ-018 With ML_DEC_PIPE_EN, a stored metric SHALL be compared one cycle after its transfer; in_ready in ACC SHALL stay 1, because the pipeline is fully streaming.

Reset
REQ-019 When rst=1 at a clock edge, the block SHALL apply: state=ACC, cnt=0, out_valid=0, in_ready=1 after release, best_cand=0, best_metric=0, best_sym=0, pipeline valid=0.
REQ-020 Reset asserted mid-frame or in OUT SHALL discard the partial frame and any pending decision.

Configuration
REQ-021 Macro ML_DECISION_TRACKER_PIPE_EN defined SHALL insert one register stage between the metric sum and the compare, enabling DRAIN with +1 latency.
REQ-022 With ML_DECISION_TRACKER_PIPE_EN undefined, the sum and compare SHALL be combinational in the transfer cycle and DRAIN SHALL be unreachable.

Structure
REQ-023 A shared package ml_det_pkg SHALL hold: the PAM level constants (-3,-1,1,3), the level-index width (3), the FSM state enum, and the best_sym field layout.
REQ-024 The metric adder SHALL be a single sub-module, ml_metric_sum, containing the four-input adder and the optional pipe register.

Verification (NUM_CAND=4, Q=22; 1.0 = 0x00400000)
REQ-025 Four candidates with metrics 8.0, 3.0, 5.0, 3.0 SHALL produce best_cand=1, best_metric=3.0, and best_sym of candidate 1 (tie goes to the lower index).
REQ-026 Holding out_ready=0 for 10 cycles in OUT SHALL keep outputs stable with in_ready=0; a 5th in_valid SHALL be ignored; out_ready=1 SHALL return the FSM to ACC.
REQ-027 Asserting rst after 2 of 4 transfers, then sending a new 4-candidate frame, SHALL select the winner from the new frame only.
REQ-028 Back-to-back frames with in_valid held high SHALL see in_ready drop for exactly the OUT cycles (plus 1 DRAIN cycle with the macro), with no candidate lost.
REQ-029 All-zero inputs SHALL give best_metric=0 and best_cand=0; inputs all 0x3FFFFFFF SHALL give best_metric=0x0FFFFFFFC with no wrap.
REQ-030 The same stimulus run with and without the macro SHALL produce identical results, with out_valid arriving 1 cycle later when the macro is defined.

Source files
------------

// File: rtl/ml_det_pkg.sv
// ml_det_pkg: shared definitions for the ML decision tracker.
//   - PAM-4 level constants and a helper that maps a level index (0..3) to its value.
//   - Level-index width and the packed best_sym layout {i1, q1, i2, q2}.
//   - FSM state encoding used by ml_decision_tracker.
package ml_det_pkg;

    localparam int LVL_W   = 3;
    localparam int NUM_LVL = 4;
    localparam int SYM_W   = 4 * LVL_W;

    localparam int signed PAM_LVL_0 = -3;
    localparam int signed PAM_LVL_1 = -1;
    localparam int signed PAM_LVL_2 = 1;
    localparam int signed PAM_LVL_3 = 3;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    // Field order matches best_sym: idx_I1 in the MSBs, idx_Q2 in the LSBs.
    typedef struct packed {
        logic [LVL_W-1:0] i1;
        logic [LVL_W-1:0] q1;
        logic [LVL_W-1:0] i2;
        logic [LVL_W-1:0] q2;
    } sym_t;

    function automatic int signed pam_level(input logic [LVL_W-1:0] idx);
        case (idx)
            3'd0:    return PAM_LVL_0;
            3'd1:    return PAM_LVL_1;
            3'd2:    return PAM_LVL_2;
            default: return PAM_LVL_3;
        endcase
    endfunction

endpackage

// File: rtl/ml_metric_sum.sv
// ml_metric_sum: four-input metric adder with an optional register stage.
// Configuration macro: ML_DECISION_TRACKER_PIPE_EN
//   undefined - sum, valid and tag pass through combinationally.
//   defined   - sum, valid and tag are registered (one cycle of latency).
// Ports:
//   clk, rst            clock / synchronous active-high reset (pipelined build only)
//   in_valid            operands present this cycle
//   d_i1..d_q2   [N]    non-negative distances, summed unsigned at N+2 bits
//   tag_in   [TAG_W]    side data travelling with the sum (candidate index, symbol)
//   out_valid, sum, tag_out   result presented to the compare stage
module ml_metric_sum #(
    parameter int N     = 32,
    parameter int Q     = 22,
    parameter int TAG_W = 16
) (
`ifdef ML_DECISION_TRACKER_PIPE_EN
    input  logic             clk,
    input  logic             rst,
`endif
    input  logic             in_valid,
    input  logic [N-1:0]     d_i1,
    input  logic [N-1:0]     d_q1,
    input  logic [N-1:0]     d_i2,
    input  logic [N-1:0]     d_q2,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    output logic [N+1:0]     sum,
    output logic [TAG_W-1:0] tag_out
);

    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("ml_metric_sum: Q must lie in 0..N-1");
    end

    logic [N+1:0] sum_c;

    // Two guard bits make four N-bit operands impossible to wrap.
    assign sum_c = {2'b00, d_i1} + {2'b00, d_q1} + {2'b00, d_i2} + {2'b00, d_q2};

`ifdef ML_DECISION_TRACKER_PIPE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            tag_out   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum     <= sum_c;
                tag_out <= tag_in;
            end
        end
    end
`else
    assign out_valid = in_valid;
    assign sum       = sum_c;
    assign tag_out   = tag_in;
`endif

endmodule

// File: rtl/ml_decision_tracker.sv
// ml_decision_tracker: picks the minimum-metric candidate of each NUM_CAND-candidate
// frame and presents it with a valid/ready handshake.
// Configuration macro: ML_DECISION_TRACKER_PIPE_EN (adds a register between the
// metric sum and the compare, plus one DRAIN cycle at the end of each frame).
// Ports:
//   clk, rst                      clock / synchronous active-high reset
//   in_valid, in_ready            candidate handshake (in_ready high only in ACC)
//   min_dI1..min_dQ2      [N]     per-dimension minimum squared distances
//   min_idx_dI1..min_idx_dQ2 [3]  PAM level indices of those distances
//   out_valid, out_ready          decision handshake (held until accepted)
//   best_cand [CW], best_metric [N+2], best_sym [12]   winning candidate
module ml_decision_tracker
    import ml_det_pkg::*;
#(
    parameter int N        = 32,
    parameter int Q        = 22,
    parameter int NUM_CAND = 16,
    parameter int CW       = $clog2(NUM_CAND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     min_dI1,
    input  logic [N-1:0]     min_dQ1,
    input  logic [N-1:0]     min_dI2,
    input  logic [N-1:0]     min_dQ2,
    input  logic [LVL_W-1:0] min_idx_dI1,
    input  logic [LVL_W-1:0] min_idx_dQ1,
    input  logic [LVL_W-1:0] min_idx_dI2,
    input  logic [LVL_W-1:0] min_idx_dQ2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    best_cand,
    output logic [N+1:0]     best_metric,
    output logic [SYM_W-1:0] best_sym
);

    if (NUM_CAND < 2 || NUM_CAND > 256) begin : g_bad_num_cand
        $error("ml_decision_tracker: NUM_CAND must lie in 2..256");
    end

    localparam int            TAG_W = CW + SYM_W;
    localparam logic [CW-1:0] LAST  = CW'(NUM_CAND - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             xfer;
    sym_t             sym_in;
    logic             cmp_valid;
    logic [N+1:0]     cmp_metric;
    logic [TAG_W-1:0] cmp_tag;
    logic [CW-1:0]    cmp_cand;
    sym_t             cmp_sym;
    logic             take;

    assign xfer   = in_valid && in_ready;
    assign sym_in = {min_idx_dI1, min_idx_dQ1, min_idx_dI2, min_idx_dQ2};

    // The candidate index travels with the sum, so the compare stage knows which
    // candidate opens the frame even when it lags the transfer by a cycle.
    ml_metric_sum #(
        .N     (N),
        .Q     (Q),
        .TAG_W (TAG_W)
    ) u_sum (
`ifdef ML_DECISION_TRACKER_PIPE_EN
        .clk       (clk),
        .rst       (rst),
`endif
        .in_valid  (xfer),
        .d_i1      (min_dI1),
        .d_q1      (min_dQ1),
        .d_i2      (min_dI2),
        .d_q2      (min_dQ2),
        .tag_in    ({cnt, sym_in}),
        .out_valid (cmp_valid),
        .sum       (cmp_metric),
        .tag_out   (cmp_tag)
    );

    assign {cmp_cand, cmp_sym} = cmp_tag;

    // Strict less-than keeps the earlier (lower-index) candidate on ties.
    assign take = cmp_valid && ((cmp_cand == '0) || (cmp_metric < best_metric));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (xfer && (cnt == LAST)) begin
`ifdef ML_DECISION_TRACKER_PIPE_EN
                    state_nxt = DRAIN;
`else
                    state_nxt = OUT;
`endif
                end
            end
            DRAIN: begin
                state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ACC;
                end
            end
            default: begin
                state_nxt = ACC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (xfer) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            best_cand   <= '0;
            best_metric <= '0;
            best_sym    <= '0;
        end else if (take) begin
            best_cand   <= cmp_cand;
            best_metric <= cmp_metric;
            best_sym    <= cmp_sym;
        end
    end

endmodule

// File: tb/tb_ml_decision_tracker.sv
// Self-checking bench for ml_decision_tracker with NUM_CAND=4, N=32, Q=22.
// Frames come from a table; each frame's expected decision is pushed to a
// scoreboard when its last candidate transfers and popped when accepted.
module tb_ml_decision_tracker;

`ifdef ML_DECISION_TRACKER_PIPE_EN
    localparam int D = 1;
`else
    localparam int D = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] min_dI1, min_dQ1, min_dI2, min_dQ2;
    logic [2:0]  min_idx_dI1, min_idx_dQ1, min_idx_dI2, min_idx_dQ2;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  best_cand;
    logic [33:0] best_metric;
    logic [11:0] best_sym;

    ml_decision_tracker #(
        .N        (32),
        .Q        (22),
        .NUM_CAND (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .min_dI1     (min_dI1),
        .min_dQ1     (min_dQ1),
        .min_dI2     (min_dI2),
        .min_dQ2     (min_dQ2),
        .min_idx_dI1 (min_idx_dI1),
        .min_idx_dQ1 (min_idx_dQ1),
        .min_idx_dI2 (min_idx_dI2),
        .min_idx_dQ2 (min_idx_dQ2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .best_cand   (best_cand),
        .best_metric (best_metric),
        .best_sym    (best_sym)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][3:0][31:0] d;
        logic [3:0][11:0]      sym;
        logic [1:0]            exp_cand;
        logic [33:0]           exp_metric;
        logic [11:0]           exp_sym;
    } frame_t;

    typedef struct packed {
        logic [1:0]  cand;
        logic [33:0] metric;
        logic [11:0] sym;
    } exp_t;

    frame_t tbl [5];
    exp_t   sb [$];
    int     pass_cnt = 0;
    int     chk_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_cand(input int f, input int c, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] e, input logic [31:0] g, input logic [11:0] s);
        tbl[f].d[c][0] = a;
        tbl[f].d[c][1] = b;
        tbl[f].d[c][2] = e;
        tbl[f].d[c][3] = g;
        tbl[f].sym[c]  = s;
    endtask

    task automatic set_exp(input int f, input logic [1:0] c, input logic [33:0] m, input logic [11:0] s);
        tbl[f].exp_cand   = c;
        tbl[f].exp_metric = m;
        tbl[f].exp_sym    = s;
    endtask

    task automatic drive_inputs(input int f, input int c);
        logic [11:0] s;
        min_dI1 = tbl[f].d[c][0];
        min_dQ1 = tbl[f].d[c][1];
        min_dI2 = tbl[f].d[c][2];
        min_dQ2 = tbl[f].d[c][3];
        s = tbl[f].sym[c];
        {min_idx_dI1, min_idx_dQ1, min_idx_dI2, min_idx_dQ2} = s;
    endtask

    // Metric 0: would win any frame it leaked into.
    task automatic drive_junk();
        {min_dI1, min_dQ1, min_dI2, min_dQ2} = '0;
        {min_idx_dI1, min_idx_dQ1, min_idx_dI2, min_idx_dQ2} = 12'o1230;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 0);
        check({tag, "_in_ready"}, 64'(in_ready), 1);
        check({tag, "_best_cand"}, 64'(best_cand), 0);
        check({tag, "_best_metric"}, 64'(best_metric), 0);
        check({tag, "_best_sym"}, 64'(best_sym), 0);
    endtask

    // Streams nf consecutive table frames with in_valid held high. The first
    // decision is held for `hold` cycles with out_ready low; junk is offered
    // while the final decision waits.
    task automatic run_frames(input int f0, input int nf, input int hold);
        int   k, total, popped, cyc, lowcnt, last_xfer, hold_left;
        bit   seen;
        exp_t e;
        k = 0; total = nf * 4; popped = 0; cyc = 0; lowcnt = 0;
        last_xfer = 0; hold_left = hold; seen = 1'b0;
        while (popped < nf && cyc < 300) begin
            if (!in_ready) lowcnt++;
            out_ready = 1'b0;
            if (out_valid) begin
                check("sb_depth", 64'(sb.size()), 1);
                if (sb.size() == 0) begin
                    out_ready = 1'b1;
                    popped++;
                end else begin
                    e = sb[0];
                    if (!seen) begin
                        check("latency", 64'(cyc - last_xfer), 64'(1 + D));
                        seen = 1'b1;
                    end
                    check("best_cand", 64'(best_cand), 64'(e.cand));
                    check("best_metric", 64'(best_metric), 64'(e.metric));
                    check("best_sym", 64'(best_sym), 64'(e.sym));
                    check("in_ready_in_out", 64'(in_ready), 0);
                    if (hold_left > 0) begin
                        hold_left--;
                    end else begin
                        out_ready = 1'b1;
                        void'(sb.pop_front());
                        popped++;
                        seen = 1'b0;
                    end
                end
            end
            if (k < total) begin
                drive_inputs(f0 + k / 4, k % 4);
                in_valid = 1'b1;
                if (in_ready) begin
                    if (k % 4 == 3) begin
                        sb.push_back('{cand: tbl[f0 + k / 4].exp_cand,
                                       metric: tbl[f0 + k / 4].exp_metric,
                                       sym: tbl[f0 + k / 4].exp_sym});
                        last_xfer = cyc;
                    end
                    k++;
                end
            end else begin
                drive_junk();
                in_valid = out_valid;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("frames_done", 64'(popped), 64'(nf));
        check("in_ready_low_cycles", 64'(lowcnt), 64'(nf * (1 + D) + hold));
        check("acc_in_ready", 64'(in_ready), 1);
        check("acc_out_valid", 64'(out_valid), 0);
    endtask

    initial begin
        // F0: metrics 8.0, 3.0, 5.0, 3.0 (1.0 = 0x00400000); tie -> candidate 1
        set_cand(0, 0, 32'h0200_0000, 0, 0, 0, 12'o0123);
        set_cand(0, 1, 32'h0040_0000, 32'h0040_0000, 32'h0020_0000, 32'h0020_0000, 12'o3210);
        set_cand(0, 2, 0, 0, 0, 32'h0140_0000, 12'o1111);
        set_cand(0, 3, 32'h00C0_0000, 0, 0, 0, 12'o2222);
        set_exp(0, 2'd1, 34'h000C0_0000, 12'o3210);
        // F1: descending 4.0, 3.0, 2.0, 1.0 -> last candidate wins
        set_cand(1, 0, 0, 32'h0100_0000, 0, 0, 12'o0003);
        set_cand(1, 1, 0, 32'h00C0_0000, 0, 0, 12'o0030);
        set_cand(1, 2, 0, 32'h0080_0000, 0, 0, 12'o0300);
        set_cand(1, 3, 0, 32'h0040_0000, 0, 0, 12'o2310);
        set_exp(1, 2'd3, 34'h00040_0000, 12'o2310);
        // F2: all zero -> candidate 0, metric 0
        set_cand(2, 0, 0, 0, 0, 0, 12'o0001);
        set_cand(2, 1, 0, 0, 0, 0, 12'o0002);
        set_cand(2, 2, 0, 0, 0, 0, 12'o0003);
        set_cand(2, 3, 0, 0, 0, 0, 12'o0010);
        set_exp(2, 2'd0, 34'h0, 12'o0001);
        // F3: every input 0x3FFFFFFF -> 0x0FFFFFFFC, candidate 0
        for (int c = 0; c < 4; c++)
            set_cand(3, c, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h3FFF_FFFF, 12'o3333 - 12'(c));
        set_exp(3, 2'd0, 34'h0_FFFF_FFFC, 12'o3333);
        // F4: large metrics near 2^31: 0x1FFFFFFFC, 0x80000000, 0x7FFFFFFF, 0x80000000
        set_cand(4, 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 12'o1000);
        set_cand(4, 1, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 32'h2000_0000, 12'o0100);
        set_cand(4, 2, 32'h7FFF_FFFF, 0, 0, 0, 12'o0010);
        set_cand(4, 3, 32'h7FFF_FFFF, 32'h0000_0001, 0, 0, 12'o0001);
        set_exp(4, 2'd2, 34'h0_7FFF_FFFF, 12'o0010);

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive_junk();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        // Decision held 10 cycles under back-pressure with a 5th in_valid offered.
        run_frames(0, 1, 10);
        run_frames(1, 1, 0);
        run_frames(2, 1, 0);
        run_frames(3, 1, 0);
        run_frames(4, 1, 0);

        // Reset after two transfers of a frame whose candidates would win.
        check("pre_junk_in_ready", 64'(in_ready), 1);
        drive_junk();
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("midframe_rst");
        run_frames(0, 1, 0);

        // Reset while a decision is pending in OUT.
        for (int c = 0; c < 4; c++) begin
            drive_inputs(4, c);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5 && !out_valid; i++) @(negedge clk);
        check("reached_out", 64'(out_valid), 1);
        check("out_metric_before_rst", 64'(best_metric), 64'(tbl[4].exp_metric));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("out_rst");

        // Back-to-back frames, in_valid held high, consumer always ready.
        run_frames(0, 2, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
